// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_ctrl                                              |
// | Description : Multi-cycle control FSM for the 16-bit CPU datapath, with a  |
// |               bounded memory-wait counter. Optional illegal-opcode trap    |
// |               enabled by `define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int unsigned OPW         = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           alusrc_a,
  output logic [1:0]     alusrc_b,
  output logic [2:0]     alu_op,
  output logic           regwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic [2:0]     state,
  output logic           mem_err,
  output logic           illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_LW   = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_SW   = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Value of the counter during the last wait cycle the memory is allowed.
  localparam logic [CW-1:0] TMO_LAST = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;
  logic          illegal_q, illegal_d;

  logic is_rtype, is_legal, waiting, timeout_hit;

  always_comb begin
    is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
               (opcode == OP_OR)  || (opcode == OP_SLT);
    is_legal = is_rtype || (opcode == OP_ADDI) || (opcode == OP_LW) ||
               (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
               (opcode == OP_HALT);
    waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    timeout_hit = (MEM_TIMEOUT != 0) && waiting && (wait_cnt_q == TMO_LAST);
  end

  always_comb begin
    state_d   = state_q;
    mem_err_d = mem_err_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alusrc_a  = 1'b0;
    alusrc_b  = 2'b00;
    alu_op    = ALU_AND;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        alusrc_b = 2'b01;
        alu_op   = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_HALT;
          mem_err_d = 1'b1;
        end
      end

      S_DECODE: begin
        alusrc_b = 2'b11;
        alu_op   = ALU_ADD;
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (!is_legal) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_d   = S_HALT;
          illegal_d = 1'b1;
`else
          state_d   = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alusrc_a = 1'b1;
        if (is_rtype) begin
          alusrc_b = 2'b00;
          case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
          state_d = S_WB;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
          alusrc_b = 2'b00;
          alu_op   = ALU_SUB;
          pc_src   = 2'b01;
          pc_write = (opcode == OP_BEQ) ? zero : !zero;
          state_d  = S_FETCH;
        end else begin
          alusrc_b = 2'b10;
          alu_op   = ALU_ADD;
          state_d  = (opcode == OP_ADDI) ? S_WB : S_MEM;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d   = S_HALT;
          mem_err_d = 1'b1;
        end
      end

      S_WB: begin
        regwrite = 1'b1;
        regdst   = is_rtype;
        memtoreg = (opcode == OP_LW);
        state_d  = S_FETCH;
      end

      default: state_d = S_HALT;
    endcase

    // Each new memory access gets a fresh wait budget.
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_cnt_d = '0;
    end else if (waiting) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end

    if (reset) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      iord     = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src   = 2'b00;
      alusrc_a = 1'b0;
      alusrc_b = 2'b00;
      alu_op   = 3'b000;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
  assign illegal = illegal_q;
`else
  assign illegal_q = 1'b0;
  assign illegal   = 1'b0;
`endif

  assign state   = state_q;
  assign mem_err = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_ctrl                                           |
// | Description : Directed self-checking bench for multicycle_ctrl.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset, reset1;
  logic [3:0] opcode;
  logic       zero, mem_ready, mem_ready1;

  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src, alusrc_b;
  logic       alusrc_a, regwrite, regdst, memtoreg, mem_err, illegal;
  logic [2:0] alu_op, state;

  logic       mem_req1, mem_we1, iord1, ir_write1, pc_write1;
  logic [1:0] pc_src1, alusrc_b1;
  logic       alusrc_a1, regwrite1, regdst1, memtoreg1, mem_err1, illegal1;
  logic [2:0] alu_op1, state1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multicycle_ctrl #(.OPW(4), .MEM_TIMEOUT(15)) u_dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
    .alu_op(alu_op), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .state(state), .mem_err(mem_err), .illegal(illegal)
  );

  multicycle_ctrl #(.OPW(4), .MEM_TIMEOUT(0)) u_dut_notmo (
    .clock(clock), .reset(reset1), .opcode(opcode), .zero(zero), .mem_ready(mem_ready1),
    .mem_req(mem_req1), .mem_we(mem_we1), .iord(iord1), .ir_write(ir_write1),
    .pc_write(pc_write1), .pc_src(pc_src1), .alusrc_a(alusrc_a1), .alusrc_b(alusrc_b1),
    .alu_op(alu_op1), .regwrite(regwrite1), .regdst(regdst1), .memtoreg(memtoreg1),
    .state(state1), .mem_err(mem_err1), .illegal(illegal1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic restart(input logic [3:0] op, input logic rdy);
    reset = 1'b1;
    tick();
    opcode    = op;
    mem_ready = rdy;
    reset     = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; reset1 = 1'b1;
    opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0; mem_ready1 = 1'b0;
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_ctrl", {ir_write, pc_write, alusrc_b, alu_op}, 0);

    // ADD: 0,1,2,4,0
    restart(4'h0, 1'b1);
    check("add_f_state", state, 0);
    check("add_f_ctrl", {mem_req, iord, ir_write, pc_write, pc_src, alusrc_a, alusrc_b, alu_op},
          {1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 3'b010});
    tick();
    check("add_d_state", state, 1);
    check("add_d_ctrl", {mem_req, alusrc_a, alusrc_b, alu_op}, {1'b0, 1'b0, 2'b11, 3'b010});
    tick();
    check("add_e_state", state, 2);
    check("add_e_ctrl", {alusrc_a, alusrc_b, alu_op, regwrite}, {1'b1, 2'b00, 3'b010, 1'b0});
    tick();
    check("add_wb_state", state, 4);
    check("add_wb_ctrl", {regwrite, regdst, memtoreg}, 3'b110);
    tick();
    check("add_done_state", state, 0);

    // SUB then SLT alu_op in EXEC
    opcode = 4'h1; tick(); tick();
    check("sub_e_aluop", alu_op, 3'b110);
    tick(); tick();
    opcode = 4'h4; tick(); tick();
    check("slt_e_aluop", alu_op, 3'b111);
    tick(); tick();

    // LW with three wait cycles in MEM: 8 cycles total
    opcode = 4'h6;
    check("lw_f_state", state, 0);
    tick(); tick();
    check("lw_e_ctrl", {state, alusrc_a, alusrc_b, alu_op}, {3'd2, 1'b1, 2'b10, 3'b010});
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lw_mem_wait", {state, mem_req, iord, mem_we}, {3'd3, 1'b1, 1'b1, 1'b0});
    end
    tick();
    mem_ready = 1'b1; #1;
    check("lw_mem_last", {state, mem_req, iord, mem_we}, {3'd3, 1'b1, 1'b1, 1'b0});
    tick();
    check("lw_wb_ctrl", {state, regwrite, regdst, memtoreg}, {3'd4, 1'b1, 1'b0, 1'b1});
    tick();
    check("lw_done_state", state, 0);

    // SW
    opcode = 4'h7; tick(); tick(); tick();
    check("sw_mem_ctrl", {state, mem_req, iord, mem_we}, {3'd3, 1'b1, 1'b1, 1'b1});
    tick();
    check("sw_done_state", state, 0);

    // BEQ / BNE with zero=1
    opcode = 4'h8; zero = 1'b1; tick(); tick();
    check("beq_e_ctrl", {state, pc_write, pc_src, alu_op, alusrc_a, alusrc_b},
          {3'd2, 1'b1, 2'b01, 3'b110, 1'b1, 2'b00});
    tick();
    check("beq_done_state", state, 0);
    opcode = 4'h9; tick(); tick();
    check("bne_e_ctrl", {state, pc_write, pc_src}, {3'd2, 1'b0, 2'b01});
    tick();
    check("bne_done_state", state, 0);
    zero = 1'b0;

    // Reset asserted mid-MEM of an LW
    opcode = 4'h6; tick(); tick();
    mem_ready = 1'b0;
    tick(); tick();
    check("rmid_pre_state", state, 3);
    reset = 1'b1; #1;
    check("rmid_state", state, 0);
    check("rmid_mem_req", mem_req, 0);
    check("rmid_mem_err", mem_err, 0);
    tick();
    reset = 1'b0; #1;
    check("rmid_rel_ctrl", {state, mem_req, iord}, {3'd0, 1'b1, 1'b0});

    // Fetch timeout after 15 waiting cycles
    for (int i = 0; i < 14; i++) tick();
    check("tmo_14_state", state, 0);
    check("tmo_14_err", mem_err, 0);
    tick();
    check("tmo_state", state, 5);
    check("tmo_mem_err", mem_err, 1);
    check("tmo_mem_req", mem_req, 0);
    mem_ready = 1'b1;
    tick(); tick();
    check("halt_hold", {state, mem_req, ir_write, pc_write, regwrite}, {3'd5, 4'b0});

    // No timeout when MEM_TIMEOUT=0
    tick();
    reset1 = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("notmo_state", state1, 0);
    check("notmo_err", {mem_err1, illegal1}, 0);
    check("notmo_ctrl",
          {mem_req1, mem_we1, iord1, ir_write1, pc_write1, pc_src1, alusrc_a1, alusrc_b1,
           alu_op1, regwrite1, regdst1, memtoreg1},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b010, 3'b000});

    // Illegal opcode 1010
    restart(4'hA, 1'b1);
    tick();
    check("ill_d_ctrl", {state, regwrite, mem_we}, {3'd1, 2'b00});
    tick();
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    check("ill_state", state, 5);
    check("ill_flag", illegal, 1);
`else
    check("ill_state", state, 0);
    check("ill_flag", illegal, 0);
`endif
    check("ill_nowrite", {regwrite, mem_we}, 0);

    // HALT opcode
    restart(4'hF, 1'b1);
    tick(); tick();
    check("halt_state", state, 5);
    check("halt_illegal", illegal, 0);
    check("halt_mem_req", mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
